// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad command queue: mode encodings, symbol codes
// and the EDIT-mode key decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_EDIT = 2'd1,
        ST_EXE  = 2'd2
    } state_t;

    localparam logic [3:0] SYM_HAT = 4'h0;
    localparam logic [3:0] SYM_ADD = 4'h1;
    localparam logic [3:0] SYM_SUB = 4'h2;
    localparam logic [3:0] SYM_MOL = 4'h3;
    localparam logic [3:0] SYM_MOR = 4'h4;
    localparam logic [3:0] SYM_INP = 4'h5;
    localparam logic [3:0] SYM_OUP = 4'h6;
    localparam logic [3:0] SYM_LOL = 4'h7;
    localparam logic [3:0] SYM_LOR = 4'h8;
    localparam logic [3:0] SYM_CEO = 4'h9;
    localparam logic [3:0] SYM_ZER = 4'hA;
    localparam logic [3:0] SYM_PAS = 4'hB;

    typedef struct packed {
        logic       mapped;
        logic       cmd;
        logic [3:0] sym;
    } dec_t;

    // The delete key wins over the symbol table so DEL_KEY may alias a symbol key.
    function automatic dec_t decode_key(input logic [15:0] key, input logic [15:0] del_key);
        dec_t d;
        d.mapped = 1'b1;
        d.cmd    = 1'b0;
        d.sym    = SYM_HAT;
        if (key == del_key) begin
            d.cmd = 1'b1;
        end else begin
            case (key)
                16'h0:   d.sym = SYM_ZER;
                16'h1:   d.sym = SYM_INP;
                16'h2:   d.sym = SYM_OUP;
                16'h3:   d.sym = SYM_PAS;
                16'h4:   d.sym = SYM_MOL;
                16'h5:   d.sym = SYM_SUB;
                16'h6:   d.sym = SYM_LOL;
                16'h7:   d.sym = SYM_MOR;
                16'h8:   d.sym = SYM_ADD;
                16'h9:   d.sym = SYM_LOR;
                16'hA:   d.sym = SYM_CEO;
                default: d.mapped = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/keypad_cmd_queue_if.sv
// Scanner-side key handshake and consumer-side valid/ready command stream.
interface keypad_cmd_queue_if #(
    parameter int KEY_W = 4,
    parameter int SYM_W = 4
);
    logic             key_available;
    logic [KEY_W-1:0] key;
    logic             pull_key;
    logic             out_valid;
    logic             out_ready;
    logic             out_cmd;
    logic [SYM_W-1:0] out_symbol;

    modport master (
        input  key_available, key, out_ready,
        output pull_key, out_valid, out_cmd, out_symbol
    );

    modport slave (
        output key_available, key, out_ready,
        input  pull_key, out_valid, out_cmd, out_symbol
    );
endinterface

// File: rtl/keypad_cmd_fifo.sv
// Show-ahead synchronous FIFO with flush; head data reads as zero while empty.
module keypad_cmd_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             working_clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full       = (count_q == CW'(DEPTH));
    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && head_valid && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge working_clock or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/keypad_cmd_queue.sv
// Keypad driver: pulls scanner keys, decodes them by mode (EDIT/EXE) and queues
// the resulting commands for a valid/ready consumer.
module keypad_cmd_queue
    import keypad_pkg::*;
#(
    parameter int KEY_W = 4,
    parameter int SYM_W = 4,
    parameter int DEPTH = 8,
    parameter logic [KEY_W-1:0] DEL_KEY = 4'hB
) (
    input  logic                     working_clock,
    input  logic                     reset,
    keypad_cmd_queue_if.master       bus,
    input  logic                     change_mode,
    input  logic                     to_mode,
    output logic [1:0]               mode_state,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               drop_count
);

    state_t       state_q, state_d;
    logic         pull_key_q, pull_key_d;
    logic [7:0]   drop_count_q, drop_count_d;

    dec_t         dec;
    logic         flush, key_try, is_edit, mapped, pop;
    logic         accept_push, accept_drop;
    logic         fifo_full, head_valid;
    logic [SYM_W:0] push_data, head_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (change_mode) state_d = to_mode ? ST_EXE : ST_EDIT;
            ST_EDIT: if (change_mode && to_mode) state_d = ST_EXE;
            ST_EXE:  if (change_mode && !to_mode) state_d = ST_EDIT;
            default: state_d = ST_INIT;
        endcase
    end

    // Only a real EDIT<->EXE switch discards queued commands.
    assign flush = change_mode && ((state_q == ST_EDIT && to_mode) ||
                                   (state_q == ST_EXE && !to_mode));

    assign is_edit = (state_q == ST_EDIT);
    assign key_try = (is_edit || state_q == ST_EXE) && bus.key_available &&
                     !pull_key_q && !flush;

    assign dec       = decode_key(16'(bus.key), 16'(DEL_KEY));
    assign mapped    = is_edit ? dec.mapped : 1'b1;
    assign push_data = is_edit ? {dec.cmd, SYM_W'(dec.sym)} : {1'b0, SYM_W'(bus.key)};
    assign pop       = head_valid && bus.out_ready;

    // Unmapped keys are pulled and counted even when full; mapped keys wait for room.
    assign accept_push = key_try && mapped && (!fifo_full || pop);
    assign accept_drop = key_try && !mapped;

    assign pull_key_d   = accept_push || accept_drop;
    assign drop_count_d = (accept_drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1
                                                                 : drop_count_q;

    always_ff @(posedge working_clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            pull_key_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pull_key_q   <= pull_key_d;
            drop_count_q <= drop_count_d;
        end
    end

    keypad_cmd_fifo #(
        .WIDTH (SYM_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .working_clock (working_clock),
        .reset         (reset),
        .flush         (flush),
        .push          (accept_push),
        .push_data     (push_data),
        .pop           (pop),
        .head_valid    (head_valid),
        .head_data     (head_data),
        .count         (fifo_count),
        .full          (fifo_full)
    );

    assign bus.pull_key   = pull_key_q;
    assign bus.out_valid  = head_valid;
    assign bus.out_cmd    = head_data[SYM_W];
    assign bus.out_symbol = head_data[SYM_W-1:0];
    assign mode_state     = state_q;
    assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_keypad_cmd_queue.sv
// Directed bench for keypad_cmd_queue: decode table vectors plus hand-written
// sequences for backpressure, flush, push+pop at full and async reset.
module tb_keypad_cmd_queue;

    logic       working_clock = 1'b0;
    logic       reset         = 1'b1;
    logic       change_mode   = 1'b0;
    logic       to_mode       = 1'b0;
    logic [1:0] mode_state;
    logic [3:0] fifo_count;
    logic [7:0] drop_count;

    keypad_cmd_queue_if #(.KEY_W(4), .SYM_W(4)) bus ();

    keypad_cmd_queue #(
        .KEY_W   (4),
        .SYM_W   (4),
        .DEPTH   (8),
        .DEL_KEY (4'hB)
    ) dut (
        .working_clock (working_clock),
        .reset         (reset),
        .bus           (bus),
        .change_mode   (change_mode),
        .to_mode       (to_mode),
        .mode_state    (mode_state),
        .fifo_count    (fifo_count),
        .drop_count    (drop_count)
    );

    always #5 working_clock = ~working_clock;

    int         total = 0;
    int         bad   = 0;
    int         pull_count = 0;
    int         exp_drop = 0;
    logic [3:0] scan_q [$];

    // Scanner model: holds queued keys and pops one whenever pull_key is seen.
    initial begin
        bus.key_available = 1'b0;
        bus.key           = 4'h0;
        forever begin
            @(negedge working_clock);
            if (bus.pull_key && scan_q.size() != 0) begin
                void'(scan_q.pop_front());
                pull_count++;
            end
            bus.key_available = (scan_q.size() != 0);
            if (scan_q.size() != 0) bus.key = scan_q[0];
        end
    end

    task automatic tick();
        @(posedge working_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_pull();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.pull_key && n < 20);
        check("pull_timeout", 32'(bus.pull_key), 32'd1);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic       exe;
        logic [3:0] key;
        logic       valid;
        logic       cmd;
        logic [3:0] sym;
    } vec_t;

    vec_t       vecs [19];
    logic [3:0] exp_q [$];
    logic       cur_exe;
    int         base;

    initial begin
        vecs[0]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hA};
        vecs[1]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h5};
        vecs[2]  = '{1'b0, 4'h2, 1'b1, 1'b0, 4'h6};
        vecs[3]  = '{1'b0, 4'h3, 1'b1, 1'b0, 4'hB};
        vecs[4]  = '{1'b0, 4'h4, 1'b1, 1'b0, 4'h3};
        vecs[5]  = '{1'b0, 4'h5, 1'b1, 1'b0, 4'h2};
        vecs[6]  = '{1'b0, 4'h6, 1'b1, 1'b0, 4'h7};
        vecs[7]  = '{1'b0, 4'h7, 1'b1, 1'b0, 4'h4};
        vecs[8]  = '{1'b0, 4'h8, 1'b1, 1'b0, 4'h1};
        vecs[9]  = '{1'b0, 4'h9, 1'b1, 1'b0, 4'h8};
        vecs[10] = '{1'b0, 4'hA, 1'b1, 1'b0, 4'h9};
        vecs[11] = '{1'b0, 4'hB, 1'b1, 1'b1, 4'h0};
        vecs[12] = '{1'b0, 4'hC, 1'b0, 1'b0, 4'h0};
        vecs[13] = '{1'b0, 4'hD, 1'b0, 1'b0, 4'h0};
        vecs[14] = '{1'b0, 4'hE, 1'b0, 1'b0, 4'h0};
        vecs[15] = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h0};
        vecs[16] = '{1'b1, 4'hB, 1'b1, 1'b0, 4'hB};
        vecs[17] = '{1'b1, 4'hF, 1'b1, 1'b0, 4'hF};
        vecs[18] = '{1'b1, 4'h3, 1'b1, 1'b0, 4'h3};

        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_mode", 32'(mode_state), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pull", 32'(bus.pull_key), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b0;
        tick();

        // Keys offered in INIT are not taken.
        scan_q.push_back(4'h8);
        repeat (3) tick();
        check("init_no_pull", 32'(pull_count), 32'd0);
        check("init_count", 32'(fifo_count), 32'd0);

        // INIT -> EDIT, then key 8 is accepted.
        change_mode = 1'b1;
        to_mode     = 1'b0;
        tick();
        change_mode = 1'b0;
        check("t1_mode", 32'(mode_state), 32'd1);
        tick();
        check("t1_pull", 32'(bus.pull_key), 32'd1);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_cmd", 32'(bus.out_cmd), 32'd0);
        check("t1_sym", 32'(bus.out_symbol), 32'd1);
        check("t1_count", 32'(fifo_count), 32'd1);
        tick();
        check("t1_pull_pulse", 32'(bus.pull_key), 32'd0);
        pop_one();
        check("t1_popped", 32'(fifo_count), 32'd0);

        // Backpressure: 9 mapped keys with the consumer stalled.
        base = pull_count;
        for (int k = 0; k < 9; k++) scan_q.push_back(4'(k));
        repeat (24) tick();
        check("t2_pulled8", 32'(pull_count - base), 32'd8);
        check("t2_count8", 32'(fifo_count), 32'd8);
        check("t2_held", 32'(bus.key_available), 32'd1);
        check("t2_head", 32'(bus.out_symbol), 32'hA);
        pop_one();
        check("t2_ninth_pull", 32'(bus.pull_key), 32'd1);
        check("t2_count_after", 32'(fifo_count), 32'd8);
        exp_q = '{4'h5, 4'h6, 4'hB, 4'h3, 4'h2, 4'h7, 4'h4, 4'h1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_order", 32'(bus.out_symbol), 32'(exp_q[i]));
            tick();
        end
        bus.out_ready = 1'b0;
        check("t2_empty", 32'(bus.out_valid), 32'd0);

        // Unmapped F is dropped, then delete key B.
        scan_q.push_back(4'hF);
        scan_q.push_back(4'hB);
        wait_pull();
        exp_drop++;
        check("t3_drop", 32'(drop_count), 32'(exp_drop));
        check("t3_no_push", 32'(fifo_count), 32'd0);
        wait_pull();
        check("t3_del_cmd", 32'(bus.out_cmd), 32'd1);
        check("t3_del_sym", 32'(bus.out_symbol), 32'd0);
        check("t3_count", 32'(fifo_count), 32'd1);
        pop_one();

        // Decode table in EDIT and pass-through in EXE.
        cur_exe = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].exe != cur_exe) begin
                change_mode = 1'b1;
                to_mode     = vecs[i].exe;
                tick();
                change_mode = 1'b0;
                cur_exe     = vecs[i].exe;
            end
            scan_q.push_back(vecs[i].key);
            wait_pull();
            if (!vecs[i].valid) exp_drop++;
            check("vec_valid", 32'(bus.out_valid), 32'(vecs[i].valid));
            check("vec_cmd", 32'(bus.out_cmd), 32'(vecs[i].cmd));
            check("vec_sym", 32'(bus.out_symbol), 32'(vecs[i].sym));
            check("vec_drop", 32'(drop_count), 32'(exp_drop));
            if (vecs[i].valid) pop_one();
        end
        check("vec_mode_exe", 32'(mode_state), 32'd2);

        // Back to EDIT, queue 3, switch to EXE flushes.
        change_mode = 1'b1;
        to_mode     = 1'b0;
        tick();
        change_mode = 1'b0;
        for (int k = 1; k <= 3; k++) scan_q.push_back(4'(k));
        repeat (3) wait_pull();
        check("t4_count3", 32'(fifo_count), 32'd3);
        change_mode = 1'b1;
        to_mode     = 1'b1;
        tick();
        change_mode = 1'b0;
        check("t4_flushed", 32'(fifo_count), 32'd0);
        check("t4_valid", 32'(bus.out_valid), 32'd0);
        check("t4_mode", 32'(mode_state), 32'd2);
        scan_q.push_back(4'h7);
        wait_pull();
        check("t4_head_cmd", 32'(bus.out_cmd), 32'd0);
        check("t4_head_sym", 32'(bus.out_symbol), 32'd7);
        pop_one();

        // Full FIFO: push and pop in the same cycle.
        for (int k = 0; k < 8; k++) scan_q.push_back(4'(k));
        repeat (8) wait_pull();
        check("t5_full", 32'(fifo_count), 32'd8);
        tick();
        bus.out_ready = 1'b1;
        scan_q.push_back(4'hC);
        tick();
        bus.out_ready = 1'b0;
        check("t5_pull", 32'(bus.pull_key), 32'd1);
        check("t5_count", 32'(fifo_count), 32'd8);
        exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t5_order", 32'(bus.out_symbol), 32'(exp_q[i]));
            tick();
        end
        bus.out_ready = 1'b0;
        check("t5_empty", 32'(fifo_count), 32'd0);

        // Async reset with 5 entries held.
        for (int k = 0; k < 5; k++) scan_q.push_back(4'(k + 3));
        repeat (5) wait_pull();
        check("t6_count5", 32'(fifo_count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_valid", 32'(bus.out_valid), 32'd0);
        check("t6_cmd", 32'(bus.out_cmd), 32'd0);
        check("t6_sym", 32'(bus.out_symbol), 32'd0);
        check("t6_mode", 32'(mode_state), 32'd0);
        check("t6_pull", 32'(bus.pull_key), 32'd0);
        check("t6_drop", 32'(drop_count), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("t6_stay_init", 32'(mode_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
